// File: rtl/p4_pipe_adder_if.sv
// rtl/p4_pipe_adder_if.sv - operand/result handshake bundle for p4_pipe_adder
interface p4_pipe_adder_if #(
    parameter int DWIDTH = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] A;
    logic [DWIDTH-1:0] B;
    logic              CIN;
    logic              SUB;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] S;
    logic              COUT;
    logic              OVF;

    modport master (
        output in_valid, A, B, CIN, SUB, out_ready,
        input  in_ready, out_valid, S, COUT, OVF
    );

    modport slave (
        input  in_valid, A, B, CIN, SUB, out_ready,
        output in_ready, out_valid, S, COUT, OVF
    );
endinterface

// File: rtl/p4_pipe_adder.sv
// rtl/p4_pipe_adder.sv - pipelined carry-chained add/sub with valid/ready flow control
// Optional saturation of S on signed overflow when P4_PIPE_SAT_EN is defined.
module p4_pipe_adder #(
    parameter int DWIDTH = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    p4_pipe_adder_if.slave   bus
);
    localparam int W   = DWIDTH / STAGES;
    localparam int L   = STAGES - 1;
    localparam int MSB = DWIDTH - 1;

    logic [DWIDTH-1:0] r_a   [STAGES];
    logic [DWIDTH-1:0] r_bx  [STAGES];
    logic [DWIDTH-1:0] r_sum [STAGES];
    logic              r_c   [STAGES];
    logic              r_v   [STAGES];

    logic [STAGES-1:0] w_adv;
    logic              w_ovf;

    // A stage may load when it is empty or its downstream neighbour is moving.
    always_comb begin
        w_adv    = '0;
        w_adv[L] = !r_v[L] || bus.out_ready;
        for (int k = L - 1; k >= 0; k--) begin
            w_adv[k] = !r_v[k] || w_adv[k+1];
        end
    end

    assign bus.in_ready = w_adv[0] && !rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [DWIDTH-1:0] w_a_src;
        logic [DWIDTH-1:0] w_bx_src;
        logic [DWIDTH-1:0] w_sum_src;
        logic [DWIDTH-1:0] w_sum_nxt;
        logic              w_c_src;
        logic              w_v_src;
        logic [W:0]        w_slice;

        if (k == 0) begin : g_head
            assign w_a_src   = bus.A;
            assign w_bx_src  = bus.SUB ? ~bus.B : bus.B;
            assign w_sum_src = '0;
            assign w_c_src   = bus.CIN ^ bus.SUB;
            assign w_v_src   = bus.in_valid;
        end else begin : g_body
            assign w_a_src   = r_a[k-1];
            assign w_bx_src  = r_bx[k-1];
            assign w_sum_src = r_sum[k-1];
            assign w_c_src   = r_c[k-1];
            assign w_v_src   = r_v[k-1];
        end

        assign w_slice = {1'b0, w_a_src[k*W +: W]} + {1'b0, w_bx_src[k*W +: W]}
                       + {{W{1'b0}}, w_c_src};

        always_comb begin
            w_sum_nxt             = w_sum_src;
            w_sum_nxt[k*W +: W]   = w_slice[W-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_v[k]   <= 1'b0;
                r_a[k]   <= '0;
                r_bx[k]  <= '0;
                r_sum[k] <= '0;
                r_c[k]   <= 1'b0;
            end else if (w_adv[k]) begin
                r_v[k]   <= w_v_src;
                r_a[k]   <= w_a_src;
                r_bx[k]  <= w_bx_src;
                r_sum[k] <= w_sum_nxt;
                r_c[k]   <= w_slice[W];
            end
        end
    end

    assign w_ovf = (r_a[L][MSB] == r_bx[L][MSB]) && (r_sum[L][MSB] != r_a[L][MSB]);

    assign bus.out_valid = r_v[L];
    assign bus.COUT      = r_c[L];
    assign bus.OVF       = w_ovf;

`ifdef P4_PIPE_SAT_EN
    assign bus.S = w_ovf ? {r_a[L][MSB], {(DWIDTH-1){~r_a[L][MSB]}}} : r_sum[L];
`else
    assign bus.S = r_sum[L];
`endif
endmodule
